// File: rtl/spectrum_byte_streamer_pkg.sv
// rtl/spectrum_byte_streamer_pkg.sv - shared types and constants for the spectrum byte streamer
package spectrum_stream_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } stream_state_t;

    localparam int HDR_BYTES = 2;
    localparam int SEQ_W     = 16;
    localparam int DROP_W    = 16;

endpackage

// File: rtl/spectrum_byte_streamer_if.sv
// rtl/spectrum_byte_streamer_if.sv - byte-wide stream interface toward the packetizer
interface spectrum_byte_streamer_if #(
    parameter int N_out = 8
);
    logic [N_out-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/spectrum_byte_streamer.sv
// rtl/spectrum_byte_streamer.sv - snapshots a spectrum and streams seq header plus payload bytes
module spectrum_byte_streamer
    import spectrum_stream_pkg::*;
#(
    parameter int BINS   = 4,
    parameter int N      = 16,
    parameter int N_out  = 8,
    localparam int NBYTES = BINS * N / N_out
) (
    input  logic                         clk,
    input  logic                         arest_n,
    input  logic                         valid,
    input  logic [NBYTES-1:0][N_out-1:0] in_data,
    spectrum_byte_streamer_if.master     m,
    output logic                         busy,
    output logic [DROP_W-1:0]            drop_count
);

    localparam int CNT_W    = $clog2(NBYTES + HDR_BYTES);
    localparam int LAST_IDX = NBYTES + HDR_BYTES - 1;

    if ((N % N_out) != 0) begin : g_width_check
        $error("spectrum_byte_streamer: N must be a multiple of N_out");
    end

    stream_state_t                state;
    logic [NBYTES-1:0][N_out-1:0] snapshot;
    logic [CNT_W-1:0]             cnt;
    logic [SEQ_W-1:0]             seq;

    logic [CNT_W-1:0] next_idx;
    logic [N_out-1:0] next_byte;
    logic [SEQ_W-1:0] seq_next;
    logic [SEQ_W-1:0] cap_seq;
    logic             accept;
    logic             last_accept;
    logic             drop;

    // Next byte to present after an accepted beat, plus capture/drop decisions
    always_comb begin
        next_idx    = cnt + 1'b1;
        seq_next    = seq + 1'b1;
        accept      = m.tvalid && m.tready;
        last_accept = accept && (cnt == CNT_W'(LAST_IDX));
        // A back-to-back capture already carries the incremented sequence number
        cap_seq     = (state == IDLE) ? seq : seq_next;
        drop        = valid && (state != IDLE) && !last_accept;
        next_byte   = '0;
        if (next_idx == CNT_W'(1)) begin
            next_byte = N_out'(seq[SEQ_W/2-1:0]);
        end
        for (int i = 0; i < NBYTES; i++) begin
            if (next_idx == CNT_W'(i + HDR_BYTES)) begin
                next_byte = snapshot[i];
            end
        end
    end

    // Frame FSM with registered stream outputs and busy flag
    always_ff @(posedge clk or negedge arest_n) begin
        if (!arest_n) begin
            state    <= IDLE;
            snapshot <= '0;
            cnt      <= '0;
            seq      <= '0;
            m.tdata  <= '0;
            m.tvalid <= 1'b0;
            m.tlast  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        snapshot <= in_data;
                        cnt      <= '0;
                        m.tdata  <= N_out'(cap_seq[SEQ_W-1:SEQ_W/2]);
                        m.tvalid <= 1'b1;
                        m.tlast  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= HDR;
                    end
                end
                HDR, PAYLOAD: begin
                    if (last_accept) begin
                        seq <= seq_next;
                        if (valid) begin
                            snapshot <= in_data;
                            cnt      <= '0;
                            m.tdata  <= N_out'(cap_seq[SEQ_W-1:SEQ_W/2]);
                            m.tlast  <= 1'b0;
                            state    <= HDR;
                        end else begin
                            m.tvalid <= 1'b0;
                            m.tlast  <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end else if (accept) begin
                        cnt     <= next_idx;
                        m.tdata <= next_byte;
                        m.tlast <= (next_idx == CNT_W'(LAST_IDX));
                        if (cnt == CNT_W'(HDR_BYTES - 1)) begin
                            state <= PAYLOAD;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    m.tvalid <= 1'b0;
                    m.tlast  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of spectra discarded while a frame is in flight
    always_ff @(posedge clk or negedge arest_n) begin
        if (!arest_n) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + 1'b1;
        end
    end

endmodule
